// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter arbiter: operand/result
// widths, watchdog default and controller state encoding.
package bcd_pkg;

  localparam int BIN_W       = 12;
  localparam int BCD_W       = 16;
  localparam int BCD_TIMEOUT = 80;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first active request at or
// above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  // pos[gi] is the requester visited gi steps after ptr
  logic [IW:0]   sum [N];
  logic [IW-1:0] pos [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pos
    assign sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
    assign pos[gi] = (sum[gi] >= (IW+1)'(N)) ? IW'(sum[gi] - (IW+1)'(N))
                                             : sum[gi][IW-1:0];
  end

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    // Walk downward so the nearest match after ptr overwrites farther ones.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[pos[k]]) begin
        gnt         = '0;
        gnt[pos[k]] = 1'b1;
        idx         = pos[k];
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one external binary-to-BCD converter between NUM_REQ requesters with
// round-robin grants, a start pulse, a per-requester result handshake and a watchdog.
module bcd_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = bcd_pkg::BIN_W,
  parameter int BCD_W   = bcd_pkg::BCD_W,
  parameter int TIMEOUT = bcd_pkg::BCD_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [BCD_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     conv_en,
  output logic [BIN_W-1:0]         conv_bin,
  input  logic [BCD_W-1:0]         conv_bcd,
  input  logic                     conv_rdy,
  output logic                     busy
);
  import bcd_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]         state_reg, state_next;
  logic [IW-1:0]      rr_ptr_reg, gnt_reg;
  logic [TW-1:0]      timer_reg;
  logic [BIN_W-1:0]   conv_bin_reg;
  logic [BCD_W-1:0]   resp_data_reg;
  logic               resp_err_reg;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               timed_out;
  logic               conv_done;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .gnt     (pick_onehot),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign timed_out = (timer_reg == TW'(TIMEOUT - 1));
  assign conv_done = (state_reg == ST_WAIT_DONE) && conv_rdy;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (pick_any) state_next = ST_START;
      ST_START:     state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (timed_out)     state_next = ST_RESP;
        else if (!conv_rdy) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (conv_rdy || timed_out) state_next = ST_RESP;
      ST_RESP:      if (resp_ready[gnt_reg]) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      gnt_reg       <= '0;
      timer_reg     <= '0;
      conv_bin_reg  <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_reg      <= pick_idx;
            conv_bin_reg <= req_data[pick_idx*BIN_W +: BIN_W];
          end
        end
        ST_START: timer_reg <= '0;
        ST_WAIT_LOW, ST_WAIT_DONE: begin
          timer_reg <= timer_reg + 1'b1;
          // A genuine completion wins over a watchdog expiry in the same cycle.
          if (state_next == ST_RESP) begin
            resp_data_reg <= conv_done ? conv_bcd : '0;
            resp_err_reg  <= !conv_done;
          end
        end
        ST_RESP: begin
          if (resp_ready[gnt_reg])
            rr_ptr_reg <= (gnt_reg == IW'(NUM_REQ - 1)) ? '0 : gnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
    assign resp_valid[gi] = (state_reg == ST_RESP) && (gnt_reg == IW'(gi));
  end

  // Gated by rst so nothing is offered while the block is held in reset.
  assign req_ready = ((state_reg == ST_IDLE) && !rst) ? pick_onehot : '0;
  assign conv_en   = (state_reg == ST_START);
  assign conv_bin  = conv_bin_reg;
  assign resp_data = resp_data_reg;
  assign resp_err  = resp_err_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a cycle-level reference model and
// a behavioural stand-in for the external converter.
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;

  localparam int N        = 4;
  localparam int BW       = 12;
  localparam int DW       = 16;
  localparam int TO       = 80;
  localparam int CONV_CYC = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*BW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [N-1:0]    resp_ready = '1;
  logic [DW-1:0]   resp_data;
  logic            resp_err, conv_en, busy;
  logic [BW-1:0]   conv_bin;
  logic [DW-1:0]   conv_bcd = '0;
  logic            conv_rdy = 1'b1;
  logic            bcd_dead = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.NUM_REQ(N), .BIN_W(BW), .BCD_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .conv_en(conv_en), .conv_bin(conv_bin),
    .conv_bcd(conv_bcd), .conv_rdy(conv_rdy), .busy(busy)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Converter stand-in: restarts on every en, rdy low for CONV_CYC cycles;
  // when bcd_dead is set it ignores en and never drops rdy.
  int            bcd_cnt = 0;
  logic [BW-1:0] bcd_op = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (conv_en) en_count <= en_count + 1;
    if (conv_en && !bcd_dead) begin
      bcd_op   <= conv_bin;
      bcd_cnt  <= CONV_CYC;
      conv_rdy <= 1'b0;
    end else if (bcd_cnt > 1) begin
      bcd_cnt <= bcd_cnt - 1;
    end else if (bcd_cnt == 1) begin
      bcd_cnt  <= 0;
      conv_rdy <= 1'b1;
      conv_bcd <= to_bcd(int'(bcd_op));
    end
  end

  // Reference model: one outstanding job, round-robin choice from m_ptr,
  // result due 3+CONV_CYC cycles after accept (2+TO on a watchdog abort).
  bit           m_out = 0, m_dead = 0;
  int           m_gnt = 0, m_op = 0, m_acc = 0, m_ptr = 0;
  int           exp_g, t, due;
  logic [N-1:0] exp_vec;
  always @(negedge clk) begin
    if (rst) begin
      m_out = 0;
      m_ptr = 0;
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_conv_en", conv_en, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_conv_bin", conv_bin, 0);
    end else if (!m_out) begin
      exp_g = -1;
      for (int k = 0; k < N; k++)
        if (exp_g < 0 && req_valid[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
      exp_vec = '0;
      if (exp_g >= 0) exp_vec[exp_g] = 1'b1;
      chk("m_req_ready", req_ready, exp_vec);
      chk("m_idle_busy", busy, 0);
      chk("m_idle_resp_valid", resp_valid, 0);
      chk("m_idle_conv_en", conv_en, 0);
      if (exp_g >= 0) begin
        m_out  = 1;
        m_gnt  = exp_g;
        m_op   = int'(req_data[exp_g*BW +: BW]);
        m_acc  = cyc;
        m_dead = bcd_dead;
      end
    end else begin
      t   = cyc - m_acc;
      due = m_dead ? 2 + TO : 3 + CONV_CYC;
      chk("m_busy", busy, 1);
      chk("m_req_ready_busy", req_ready, 0);
      chk("m_conv_en", conv_en, (t == 1) ? 1 : 0);
      chk("m_conv_bin", conv_bin, m_op);
      if (t < due) begin
        chk("m_resp_early", resp_valid, 0);
      end else begin
        exp_vec = '0;
        exp_vec[m_gnt] = 1'b1;
        chk("m_resp_valid", resp_valid, exp_vec);
        chk("m_resp_data", resp_data, m_dead ? 16'h0000 : to_bcd(m_op));
        chk("m_resp_err", resp_err, m_dead);
        if (resp_ready[m_gnt]) begin
          $display("txn req=%0d op=%0d data=%h err=%b lat=%0d", m_gnt, m_op, resp_data, resp_err, t);
          m_out = 0;
          m_ptr = (m_gnt + 1) % N;
        end
      end
    end
  end

  task automatic wait_ready(input int r, output bit ok);
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1;
    end
  endtask

  task automatic wait_resp(input int r, output bit ok);
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (resp_valid[r]) ok = 1;
    end
  endtask

  task automatic single(input int r, input int val, input logic [15:0] exp_d,
                        input logic exp_e, input int exp_lat, input string nm);
    bit ok;
    int t0, e0;
    e0 = en_count;
    req_data[r*BW +: BW] = BW'(val);
    req_valid[r] = 1'b1;
    wait_ready(r, ok);
    chk({nm, "_accept"}, ok, 1);
    t0 = cyc;
    @(posedge clk); #1 req_valid[r] = 1'b0;
    wait_resp(r, ok);
    chk({nm, "_resp"}, ok, 1);
    chk({nm, "_latency"}, cyc - t0, exp_lat);
    chk({nm, "_data"}, resp_data, exp_d);
    chk({nm, "_err"}, resp_err, exp_e);
    chk({nm, "_en_pulses"}, en_count - e0, 1);
    @(posedge clk); #1;
  endtask

  int            order [5] = '{0, 1, 2, 3, 0};
  logic [15:0]   rr_exp [5] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h0005};
  int            g, e_bp;
  bit            ok;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_conv_en", conv_en, 0);
    rst = 1'b0;

    single(0, 12'hFFF, 16'h4095, 1'b0, 23, "max");
    single(2, 0, 16'h0000, 1'b0, 23, "zero");
    single(3, 999, 16'h0999, 1'b0, 23, "ptr_wrap");

    // All four pending; requester 0 re-asserts with a new operand after its grant.
    req_data = {12'd1000, 12'd100, 12'd10, 12'd1};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = -1;
      for (int n = 0; n < 300 && g < 0; n++) begin
        @(negedge clk);
        for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
      end
      chk("rr_grant", g, order[i]);
      @(posedge clk); #1;
      if (i == 0) req_data[0 +: BW] = 12'd5;
      else req_valid[order[i]] = 1'b0;
      wait_resp(order[i], ok);
      chk("rr_resp", ok, 1);
      chk("rr_data", resp_data, rr_exp[i]);
      @(posedge clk); #1;
    end

    // Backpressure on requester 1 while requester 2 waits.
    resp_ready[1] = 1'b0;
    req_data[1*BW +: BW] = 12'd42;
    req_data[2*BW +: BW] = 12'd321;
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    wait_ready(1, ok);
    chk("bp_accept", ok, 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_resp(1, ok);
    chk("bp_resp", ok, 1);
    e_bp = en_count;
    repeat (50) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 4'b0010);
      chk("bp_data", resp_data, 16'h0042);
      chk("bp_req_ready", req_ready, 0);
    end
    chk("bp_no_en", en_count - e_bp, 0);
    @(posedge clk); #1 resp_ready[1] = 1'b1;
    wait_ready(2, ok);
    chk("bp_pending_accept", ok, 1);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_resp(2, ok);
    chk("bp_pending_data", resp_data, 16'h0321);
    @(posedge clk); #1;

    bcd_dead = 1'b1;
    single(3, 123, 16'h0000, 1'b1, 82, "timeout");
    bcd_dead = 1'b0;
    single(0, 77, 16'h0077, 1'b0, 23, "after_timeout");

    // Reset in the middle of WAIT_DONE.
    req_data[1*BW +: BW] = 12'd888;
    req_valid[1] = 1'b1;
    wait_ready(1, ok);
    chk("mid_accept", ok, 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_conv_en", conv_en, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_conv_bin", conv_bin, 0);
    @(posedge clk); #1 rst = 1'b0;
    single(2, 255, 16'h0255, 1'b0, 23, "post_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
